divisor_nibbles: RTL and testbench

Upstream feeder for the 4-bit substitution stage of the cipher datapath. Accepts plaintext bytes over a valid/ready handshake, splits each into high then low nibble, whitens each nibble with a rotating 16-bit key, and drives the substitution stage's `entrada` bus and `ready` strobe. Every strobe is a single-cycle high pulse, and `entrada` is stable one full cycle before each rising edge, so the posedge-triggered substitution stage always samples clean data.

---
 rtl/divisor_nibbles.sv | 113 +++++++++++
 tb/tb_divisor_nibbles.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_nibbles.sv
// Byte-to-nibble feeder for the 4-bit substitution stage: splits each accepted byte
// into high/low nibbles, whitens them with a rotating 16-bit key and strobes them out.
module divisor_nibbles #(
   parameter logic [15:0] KEY = 16'hA5C3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   input  logic        key_load,
   input  logic [15:0] key_in,
   output logic [3:0]  entrada,
   output logic        ready,
   output logic [7:0]  nib_count,
   output logic        busy
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SET_H = 3'd1;
   localparam logic [2:0] STB_H = 3'd2;
   localparam logic [2:0] SET_L = 3'd3;
   localparam logic [2:0] STB_L = 3'd4;

   logic [2:0]  state;
   logic [2:0]  state_next;
   logic [3:0]  byte_lo;
   logic [15:0] key;
   logic [1:0]  k;

   logic        accept;
   logic        load_lo;
   logic        load_any;
   logic [15:0] key_eff;
   logic [1:0]  k_eff;
   logic [1:0]  k_next;
   logic [3:0]  nib_key;
   logic [3:0]  nib_raw;
   logic [3:0]  nib_out;
   logic        ready_next;

   assign byte_ready = ((state == IDLE) || (state == STB_L)) & ~reset;
   assign busy       = (state != IDLE);
   assign accept     = byte_valid & byte_ready;
   assign load_lo    = (state == STB_H);
   assign load_any   = accept | load_lo;

   // A key load at the same edge as a nibble load whitens that nibble with key_in[3:0].
   assign key_eff = key_load ? key_in : key;
   assign k_eff   = key_load ? 2'd0 : k;
   assign k_next  = load_any ? k_eff + 2'd1 : k_eff;

   always_comb begin
      nib_key = key_eff[3:0];
      case (k_eff)
         2'd0:    nib_key = key_eff[3:0];
         2'd1:    nib_key = key_eff[7:4];
         2'd2:    nib_key = key_eff[11:8];
         default: nib_key = key_eff[15:12];
      endcase
   end

   assign nib_raw = accept ? byte_in[7:4] : byte_lo;
   assign nib_out = nib_raw ^ nib_key;

   always_comb begin
      state_next = state;
      ready_next = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_next = SET_H;
         end
         SET_H: begin
            state_next = STB_H;
            ready_next = 1'b1;
         end
         STB_H: begin
            state_next = SET_L;
         end
         SET_L: begin
            state_next = STB_L;
            ready_next = 1'b1;
         end
         STB_L: begin
            state_next = accept ? SET_H : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         entrada   <= '0;
         ready     <= 1'b0;
         nib_count <= '0;
         key       <= KEY;
         k         <= '0;
         byte_lo   <= '0;
      end else begin
         state <= state_next;
         ready <= ready_next;
         key   <= key_eff;
         k     <= k_next;
         if (load_any) entrada <= nib_out;
         if (accept) byte_lo <= byte_in[3:0];
         if (ready_next & ~ready) nib_count <= nib_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_divisor_nibbles.sv
// Directed bench for divisor_nibbles: handshake timing, key whitening, key_load
// collisions, mid-byte reset, count wrap and a chained substitution stage.
module tb_divisor_nibbles;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        key_load;
   logic [15:0] key_in;
   logic [3:0]  entrada;
   logic        ready;
   logic [7:0]  nib_count;
   logic        busy;

   divisor_nibbles #(.KEY(16'hA5C3)) dut (
      .clk        (clk),
      .reset      (reset),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .key_load   (key_load),
      .key_in     (key_in),
      .entrada    (entrada),
      .ready      (ready),
      .nib_count  (nib_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // PRESENT-style 4-bit S-box standing in for the downstream substitution stage
   logic [3:0] sbox [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
   logic [3:0] sub_out = 4'h0;
   always @(posedge clk) if (ready === 1'b1) sub_out <= sbox[entrada];

   int         cyc = 0;
   logic       ready_q = 1'b0;
   logic [3:0] entrada_q = 4'h0;
   int         glitch = 0;
   logic [3:0] rise_val [$];
   int         rise_cyc [$];
   int         acc_cyc [$];
   logic [7:0] acc_byte [$];
   logic [3:0] sub_log [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Negedge observer: pulse shape, entrada stability at rises, accepted bytes.
   always @(negedge clk) begin
      if (ready_q === 1'b1) sub_log.push_back(sub_out);
      if (ready === 1'b1 && ready_q === 1'b0) begin
         rise_val.push_back(entrada);
         rise_cyc.push_back(cyc);
         if (entrada !== entrada_q) glitch++;
      end
      if (ready === 1'b1 && ready_q === 1'b1) glitch++;
      if (byte_valid === 1'b1 && byte_ready === 1'b1) begin
         acc_cyc.push_back(cyc + 1);
         acc_byte.push_back(byte_in);
      end
      ready_q   = ready;
      entrada_q = entrada;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rise_val.delete();
      rise_cyc.delete();
      acc_cyc.delete();
      acc_byte.delete();
      sub_log.delete();
   endtask

   function automatic logic [7:0] dat(input int i);
      return 8'(i * 37 + 5);
   endfunction

   logic [3:0] kn [4] = '{4'h3, 4'hC, 4'h5, 4'hA};

   initial begin
      int idx;
      int cycles;
      int bad;
      logic pre;
      logic [7:0] d;
      logic [3:0] e;
      logic [3:0] exp1 [6] = '{4'h6, 4'h6, 4'h0, 4'h0, 4'h3, 4'hC};
      logic [3:0] exp3 [4] = '{4'hF, 4'hF, 4'hF, 4'h0};

      reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; key_load = 1'b0; key_in = 16'h0000;
      step(); step();
      check("rst_entrada", 32'(entrada), 32'h0);
      check("rst_ready", 32'(ready), 32'h0);
      check("rst_count", 32'(nib_count), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_byte_ready_in_reset", 32'(byte_ready), 32'h0);
      reset = 1'b0;
      #1;
      check("idle_byte_ready", 32'(byte_ready), 32'h1);

      // 0x5A twice with default key, then 0x00 to show k wrapping to nibble 0
      clear_logs();
      byte_in = 8'h5A; byte_valid = 1'b1; step(); byte_valid = 1'b0;
      check("t1_hi_loaded", 32'(entrada), 32'h6);
      check("t1_busy", 32'(busy), 32'h1);
      check("t1_byte_ready_set_h", 32'(byte_ready), 32'h0);
      repeat (4) step();
      check("t1_count2", 32'(nib_count), 32'd2);
      check("t1_idle", 32'(busy), 32'h0);
      byte_in = 8'h5A; byte_valid = 1'b1; step(); byte_valid = 1'b0;
      repeat (4) step();
      check("t1_count4", 32'(nib_count), 32'd4);
      byte_in = 8'h00; byte_valid = 1'b1; step(); byte_valid = 1'b0;
      check("t1_k_wrapped", 32'(entrada), 32'h3);
      repeat (5) step();
      check("t1_rises", 32'(rise_val.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         if (i < rise_val.size()) check($sformatf("t1_rise%0d", i), 32'(rise_val[i]), 32'(exp1[i]));
      if (rise_cyc.size() >= 2 && acc_cyc.size() >= 1) begin
         check("t1_latency_hi", 32'(rise_cyc[0] - acc_cyc[0]), 32'd1);
         check("t1_latency_lo", 32'(rise_cyc[1] - acc_cyc[0]), 32'd3);
      end
      check("t1_count6", 32'(nib_count), 32'd6);

      // key_load 0, then 0x12/0x34 with byte_valid held high
      key_in = 16'h0000; key_load = 1'b1; step(); key_load = 1'b0;
      clear_logs();
      byte_in = 8'h12; byte_valid = 1'b1; step();
      byte_in = 8'h34;
      check("t2_br_set_h", 32'(byte_ready), 32'h0);
      step();
      check("t2_br_stb_h", 32'(byte_ready), 32'h0);
      step();
      check("t2_br_set_l", 32'(byte_ready), 32'h0);
      step();
      check("t2_br_stb_l", 32'(byte_ready), 32'h1);
      step(); byte_valid = 1'b0;
      repeat (5) step();
      check("t2_accepts", 32'(acc_cyc.size()), 32'd2);
      if (acc_cyc.size() == 2) check("t2_accept_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
      check("t2_rises", 32'(rise_val.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < rise_val.size() && acc_cyc.size() > 0) begin
            check($sformatf("t2_rise%0d", i), 32'(rise_val[i]), 32'(i + 1));
            check($sformatf("t2_rise%0d_cyc", i), 32'(rise_cyc[i] - acc_cyc[0]), 32'(2 * i + 1));
         end
      check("t2_count10", 32'(nib_count), 32'd10);

      // key_load 0xFFFF coinciding with accept, then key_load 0 at the STB_H edge
      clear_logs();
      key_in = 16'hFFFF; key_load = 1'b1; byte_in = 8'h00; byte_valid = 1'b1; step();
      key_load = 1'b0; byte_valid = 1'b0;
      check("t3_hi_ffff", 32'(entrada), 32'hF);
      repeat (4) step();
      byte_in = 8'h00; byte_valid = 1'b1; step(); byte_valid = 1'b0;
      step();
      key_in = 16'h0000; key_load = 1'b1; step(); key_load = 1'b0;
      check("t3_lo_key0", 32'(entrada), 32'h0);
      repeat (4) step();
      check("t3_rises", 32'(rise_val.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < rise_val.size()) check($sformatf("t3_rise%0d", i), 32'(rise_val[i]), 32'(exp3[i]));
      check("t3_count14", 32'(nib_count), 32'd14);

      // reset while in STB_H
      clear_logs();
      byte_in = 8'hAB; byte_valid = 1'b1; step(); byte_valid = 1'b0;
      step();
      check("t4_ready_stb_h", 32'(ready), 32'h1);
      reset = 1'b1; step();
      check("t4_ready", 32'(ready), 32'h0);
      check("t4_entrada", 32'(entrada), 32'h0);
      check("t4_count", 32'(nib_count), 32'h0);
      check("t4_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      #1;
      check("t4_byte_ready", 32'(byte_ready), 32'h1);
      repeat (5) step();
      check("t4_no_more_pulses", 32'(rise_val.size()), 32'd1);

      // 128 bytes streamed, junk on byte_in whenever byte_ready is low
      clear_logs();
      idx = 0; cycles = 0;
      byte_valid = 1'b1; byte_in = dat(0);
      while (idx < 128 && cycles < 1000) begin
         pre = byte_ready;
         step();
         cycles++;
         if (pre) idx++;
         if (idx < 128) byte_in = byte_ready ? dat(idx) : 8'($urandom);
         else byte_valid = 1'b0;
      end
      byte_valid = 1'b0;
      check("t5_stream_done", 32'(idx), 32'd128);
      repeat (6) step();
      check("t5_accepts", 32'(acc_byte.size()), 32'd128);
      bad = 0;
      for (int i = 0; i < acc_byte.size(); i++) begin
         if (acc_byte[i] !== dat(i)) bad++;
         if (i > 0 && acc_cyc[i] - acc_cyc[i-1] != 4) bad++;
      end
      check("t5_captured_bytes_and_gap", 32'(bad), 32'd0);
      check("t5_rises", 32'(rise_val.size()), 32'd256);
      bad = 0;
      for (int j = 0; j < rise_val.size(); j++) begin
         d = dat(j / 2);
         e = ((j % 2) == 0 ? d[7:4] : d[3:0]) ^ kn[j % 4];
         if (rise_val[j] !== e) bad++;
      end
      check("t5_rise_values", 32'(bad), 32'd0);
      check("t5_count_wrap", 32'(nib_count), 32'h00);

      // chained substitution stage, all 16 nibbles with key 0
      key_in = 16'h0000; key_load = 1'b1; step(); key_load = 1'b0;
      clear_logs();
      for (int b = 0; b < 8; b++) begin
         byte_in = {4'(2 * b), 4'(2 * b + 1)};
         byte_valid = 1'b1;
         step();
         byte_valid = 1'b0;
         repeat (3) step();
      end
      repeat (6) step();
      check("t6_sub_results", 32'(sub_log.size()), 32'd16);
      check("t6_accepts_back_to_back", 32'(acc_cyc.size() == 8 ? acc_cyc[7] - acc_cyc[0] : -1), 32'd28);
      for (int i = 0; i < 16; i++)
         if (i < sub_log.size()) check($sformatf("t6_sbox%0d", i), 32'(sub_log[i]), 32'(sbox[i]));
      check("t6_count16", 32'(nib_count), 32'd16);

      check("pulse_shape_and_stability", 32'(glitch), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
